// File: rtl/ikili_kilit.sv
// Dual combination-lock checker: two independent 40-position dials are compared
// against their 6-bit codes, and one registered flag reports when both locks are open.
module ikili_kilit (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  sag_adimlar,
    input  logic [3:0]  sol_adimlar,
    input  logic [11:0] kilit_sifreler,
    output logic        kilitler_acik
);

    localparam int unsigned NumLocks = 2;
    localparam int unsigned RWidth   = 3;
    localparam int unsigned LWidth   = 2;
    localparam int unsigned CWidth   = 6;

    // Computes the dial position as (5*R + 30*L) mod 40. A left step of -10 is
    // the same as +30 on a 40-position dial. The sum is at most 125, so at most
    // two conditional subtractions bring it into the range 0..39.
    function automatic logic [6:0] dial_position(input logic [RWidth-1:0] r,
                                                 input logic [LWidth-1:0] l);
        logic [6:0] sum;
        sum = 7'(7'd5 * 7'(r)) + 7'(7'd30 * 7'(l));
        if (sum >= 7'd80) begin
            sum = sum - 7'd80;
        end
        if (sum >= 7'd40) begin
            sum = sum - 7'd40;
        end
        return sum;
    endfunction

    // The code is compared at full width. Codes 40..63 never match, because the
    // position is always below 40.
    function automatic logic lock_open(input logic [RWidth-1:0] r,
                                       input logic [LWidth-1:0] l,
                                       input logic [CWidth-1:0] code);
        return dial_position(r, l) == {1'b0, code};
    endfunction

    logic [NumLocks-1:0] open_lock;
    logic                kilitler_acik_d;
    logic                kilitler_acik_q;

    always_comb begin
        open_lock = '0;
        for (int n = 0; n < NumLocks; n++) begin
            open_lock[n] = lock_open(sag_adimlar[n*RWidth +: RWidth],
                                     sol_adimlar[n*LWidth +: LWidth],
                                     kilit_sifreler[n*CWidth +: CWidth]);
        end
        kilitler_acik_d = &open_lock;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kilitler_acik_q <= 1'b0;
        end else begin
            kilitler_acik_q <= kilitler_acik_d;
        end
    end

    assign kilitler_acik = kilitler_acik_q;

endmodule

// File: tb/tb_ikili_kilit.sv
// Bench for ikili_kilit: directed cases plus randomized stimulus checked against
// an arithmetic reference model of the two dials.
module tb_ikili_kilit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sag_adimlar;
    logic [3:0]  sol_adimlar;
    logic [11:0] kilit_sifreler;
    logic        kilitler_acik;

    int total = 0;
    int bad   = 0;

    ikili_kilit dut (
        .clk            (clk),
        .rst            (rst),
        .sag_adimlar    (sag_adimlar),
        .sol_adimlar    (sol_adimlar),
        .kilit_sifreler (kilit_sifreler),
        .kilitler_acik  (kilitler_acik)
    );

    always #5 clk = ~clk;

    function automatic int ref_pos(input int r, input int l);
        int p;
        p = (5 * r - 10 * l) % 40;
        if (p < 0) p += 40;
        return p;
    endfunction

    function automatic logic ref_open(input logic [5:0] s, input logic [3:0] l,
                                      input logic [11:0] c);
        return (ref_pos(int'(s[5:3]), int'(l[3:2])) == int'(c[11:6])) &&
               (ref_pos(int'(s[2:0]), int'(l[1:0])) == int'(c[5:0]));
    endfunction

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (sag=%b sol=%b codes=%0d,%0d)",
                     tag, obs, exp, sag_adimlar, sol_adimlar,
                     kilit_sifreler[11:6], kilit_sifreler[5:0]);
        end
    endtask

    // Drives one input set, lets one edge pass and checks the registered flag.
    task automatic step(input logic r, input logic [5:0] s, input logic [3:0] l,
                        input logic [11:0] c, input string tag, input logic exp);
        rst            = r;
        sag_adimlar    = s;
        sol_adimlar    = l;
        kilit_sifreler = c;
        @(posedge clk);
        #1;
        check_eq(tag, kilitler_acik, exp);
    endtask

    int tab_r [8] = '{0, 0, 0, 1, 2, 4, 6, 7};
    int tab_l [8] = '{1, 2, 3, 1, 1, 2, 3, 0};
    int tab_p [8] = '{30, 20, 10, 35, 0, 0, 0, 35};

    initial begin
        logic [5:0]  s;
        logic [3:0]  l;
        logic [11:0] c;
        logic        exp;
        int          pulses;

        rst = 1'b1;
        sag_adimlar = '0;
        sol_adimlar = '0;
        kilit_sifreler = '0;
        @(posedge clk);
        #1;

        // Reset dominates a matching input set.
        step(1'b1, 6'd0, 4'd0, 12'd0, "rst_hold_a", 1'b0);
        step(1'b1, 6'd0, 4'd0, 12'd0, "rst_hold_b", 1'b0);
        step(1'b0, 6'd0, 4'd0, 12'd0, "rst_release", 1'b1);

        step(1'b0, 6'b010_100, 4'b01_10, 12'd0, "both_at_zero", 1'b1);
        step(1'b0, 6'b111_001, 4'b11_00, {6'd5, 6'd5}, "both_at_five", 1'b1);
        step(1'b0, 6'b111_001, 4'b11_00, {6'd5, 6'd45}, "no_code_wrap", 1'b0);
        step(1'b0, 6'b111_001, 4'b11_00, {6'd10, 6'd5}, "lock1_wrong", 1'b0);
        step(1'b0, 6'b000_000, 4'b00_01, {6'd0, 6'd30}, "neg_wrap_open", 1'b1);
        step(1'b0, 6'b000_000, 4'b00_01, {6'd0, 6'd10}, "neg_wrap_closed", 1'b0);
        step(1'b0, 6'b000_000, 4'b00_00, {6'd40, 6'd0}, "code40_closed", 1'b0);

        // Reference positions on lock 0, then the same on lock 1.
        for (int i = 0; i < 8; i++) begin
            s = {3'd0, 3'(tab_r[i])};
            l = {2'd0, 2'(tab_l[i])};
            step(1'b0, s, l, {6'd0, 6'(tab_p[i])}, "table_lock0", 1'b1);
            s = {3'(tab_r[i]), 3'd0};
            l = {2'(tab_l[i]), 2'd0};
            step(1'b0, s, l, {6'(tab_p[i]), 6'd0}, "table_lock1", 1'b1);
            step(1'b0, s, l, {6'((tab_p[i] + 5) % 40), 6'd0}, "table_off", 1'b0);
        end

        // Random sweep, biased so that roughly a quarter of the sets open both locks.
        pulses = 0;
        for (int i = 0; i < 4000; i++) begin
            s = 6'($urandom);
            l = 4'($urandom);
            c = 12'($urandom);
            if ($urandom_range(0, 1) == 1)
                c[5:0] = 6'(ref_pos(int'(s[2:0]), int'(l[1:0])));
            if ($urandom_range(0, 1) == 1)
                c[11:6] = 6'(ref_pos(int'(s[5:3]), int'(l[3:2])));
            exp = ref_open(s, l, c);
            step(1'b0, s, l, c, "random", exp);
            if (exp && kilitler_acik === 1'b1 && pulses < 6 && (i % 50) > 25) begin
                step(1'b1, s, l, c, "mid_reset", 1'b0);
                step(1'b0, s, l, c, "after_reset", 1'b1);
                pulses++;
            end
        end
        if (pulses == 0) check_eq("mid_reset_seen", 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
